// File: rtl/pipe_pkg.sv
// Shared types and default widths for the elastic pipeline stage.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  localparam int unsigned PAYLOAD_W_DEF = 160;
  localparam int unsigned CNT_W_DEF     = 16;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter, cleared only by reset.
module pipe_sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipe_elastic_stage.sv
// Elastic inter-stage register: valid/ready handshake, 2-entry skid buffer,
// synchronous flush and stall/bubble performance counters.
module pipe_elastic_stage
  import pipe_pkg::*;
#(
  parameter int unsigned PAYLOAD_W     = PAYLOAD_W_DEF,
  parameter bit          ZERO_ON_FLUSH = 1'b1,
  parameter int unsigned CNT_W         = CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PAYLOAD_W-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PAYLOAD_W-1:0] out_data,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic [CNT_W-1:0]     bubble_cnt
);

  state_e               state_q, state_d;
  logic [PAYLOAD_W-1:0] main_q, main_d;
  logic [PAYLOAD_W-1:0] skid_q, skid_d;
  logic                 in_ready_q, in_ready_d;
  logic                 out_valid_q, out_valid_d;
  logic                 in_fire, out_fire;

  always_comb begin
    state_d  = state_q;
    main_d   = main_q;
    skid_d   = skid_q;
    in_fire  = in_valid & in_ready_q;
    out_fire = out_valid_q & out_ready;

    if (flush) begin
      state_d = ST_EMPTY;
      skid_d  = '0;
      if (ZERO_ON_FLUSH) main_d = '0;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            state_d = ST_ONE;
            main_d  = in_data;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            main_d = in_data;
          end else if (in_fire) begin
            state_d = ST_TWO;
            skid_d  = in_data;
          end else if (out_fire) begin
            state_d = ST_EMPTY;
            if (ZERO_ON_FLUSH) main_d = '0;
          end
        end
        ST_TWO: begin
          // Skid drains into main; upstream was already told not-ready.
          if (out_fire) begin
            state_d = ST_ONE;
            main_d  = skid_q;
            skid_d  = '0;
          end
        end
        default: begin
          state_d = ST_EMPTY;
        end
      endcase
    end

    in_ready_d  = (state_d != ST_TWO);
    out_valid_d = (state_d != ST_EMPTY);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_q;

  pipe_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (out_valid_q & ~out_ready),
    .cnt (stall_cnt)
  );

  pipe_sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk (clk),
    .rst (rst),
    .inc (~out_valid_q),
    .cnt (bubble_cnt)
  );

endmodule

// File: tb/tb_pipe_elastic_stage.sv
// Directed vector table, random scoreboard run and counter saturation checks
// for pipe_elastic_stage.
module tb_pipe_elastic_stage;

  localparam int unsigned PW = 32;
  localparam int unsigned CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush, in_valid, out_ready;
  logic          in_ready, out_valid;
  logic [PW-1:0] in_data, out_data;
  logic [CW-1:0] stall_cnt, bubble_cnt;

  logic          s_flush, s_in_valid, s_out_ready;
  logic          s_in_ready, s_out_valid;
  logic [7:0]    s_in_data, s_out_data;
  logic [3:0]    s_stall_cnt, s_bubble_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_elastic_stage #(.PAYLOAD_W(PW), .ZERO_ON_FLUSH(1'b1), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
  );

  pipe_elastic_stage #(.PAYLOAD_W(8), .ZERO_ON_FLUSH(1'b1), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .flush(s_flush),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
    .stall_cnt(s_stall_cnt), .bubble_cnt(s_bubble_cnt)
  );

  typedef struct {
    logic          iv;
    logic          ordy;
    logic          fl;
    logic [PW-1:0] d;
    logic          ev;
    logic          er;
    logic [PW-1:0] ed;
  } vec_t;

  vec_t          vecs[$];
  logic [PW-1:0] sb[$];

  function automatic vec_t mk(logic iv, logic ordy, logic fl, logic [PW-1:0] d,
                              logic ev, logic er, logic [PW-1:0] ed);
    vec_t v;
    v.iv = iv; v.ordy = ordy; v.fl = fl; v.d = d;
    v.ev = ev; v.er = er; v.ed = ed;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic          prev_stall;
    logic [PW-1:0] prev_data;
    logic          iv, orr, fl;
    logic [PW-1:0] d;

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    s_flush = 1'b0; s_in_valid = 1'b0; s_out_ready = 1'b0; s_in_data = '0;
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_data", out_data, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_bubble_cnt", bubble_cnt, 0);
    @(negedge clk);
    rst = 1'b0;
    step();

    // Streaming at full throughput
    for (int i = 1; i <= 8; i++) vecs.push_back(mk(1, 1, 0, PW'(i), 1, 1, PW'(i)));
    vecs.push_back(mk(0, 1, 0, 0, 0, 1, 0));
    // Backpressure into the skid entry, then release
    vecs.push_back(mk(1, 0, 0, 'hA, 1, 1, 'hA));
    vecs.push_back(mk(1, 0, 0, 'hB, 1, 0, 'hA));
    vecs.push_back(mk(1, 0, 0, 'hD, 1, 0, 'hA));
    vecs.push_back(mk(1, 0, 0, 'hD, 1, 0, 'hA));
    vecs.push_back(mk(0, 1, 0, 0, 1, 1, 'hB));
    vecs.push_back(mk(0, 1, 0, 0, 0, 1, 0));
    // Flush while full with a new offer
    vecs.push_back(mk(1, 0, 0, 'h1A, 1, 1, 'h1A));
    vecs.push_back(mk(1, 0, 0, 'h1B, 1, 0, 'h1A));
    vecs.push_back(mk(1, 0, 1, 'hC, 0, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 1, 0));
    // Flush beats a simultaneous in/out transfer in ONE
    vecs.push_back(mk(1, 1, 0, 'h20, 1, 1, 'h20));
    vecs.push_back(mk(1, 1, 1, 'h21, 0, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 1, 0));
    // Fill TWO, then drain while the refused offer is retried
    vecs.push_back(mk(1, 0, 0, 'h30, 1, 1, 'h30));
    vecs.push_back(mk(1, 0, 0, 'h31, 1, 0, 'h30));
    vecs.push_back(mk(1, 1, 0, 'h32, 1, 1, 'h31));
    vecs.push_back(mk(1, 1, 0, 'h32, 1, 1, 'h32));
    vecs.push_back(mk(0, 1, 0, 0, 0, 1, 0));

    foreach (vecs[i]) begin
      in_valid = vecs[i].iv; out_ready = vecs[i].ordy;
      flush = vecs[i].fl; in_data = vecs[i].d;
      step();
      chk($sformatf("vec%0d_out_valid", i), out_valid, vecs[i].ev);
      chk($sformatf("vec%0d_in_ready", i), in_ready, vecs[i].er);
      chk($sformatf("vec%0d_out_data", i), out_data, vecs[i].ed);
    end
    chk("table_stall_cnt", stall_cnt, 6);

    // Random handshake against a scoreboard
    prev_stall = 1'b0;
    prev_data  = '0;
    for (int c = 0; c < 10004; c++) begin
      if (c < 10000) begin
        iv  = 1'($urandom_range(0, 1));
        orr = ($urandom_range(0, 3) != 0);
        fl  = ($urandom_range(0, 63) == 0);
      end else begin
        iv = 1'b0; orr = 1'b1; fl = 1'b0;
      end
      d = $urandom;
      in_valid = iv; out_ready = orr; flush = fl; in_data = d;
      if (prev_stall) begin
        chk("stall_out_valid", out_valid, 1);
        chk("stall_out_data", out_data, prev_data);
      end
      if (out_valid && orr) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb_spurious actual=%0h required=none", out_data);
        end else begin
          chk("sb_data", out_data, sb.pop_front());
        end
      end
      if (iv && in_ready && !fl) sb.push_back(d);
      if (fl) sb.delete();
      prev_stall = out_valid && !orr && !fl;
      prev_data  = out_data;
      step();
    end
    chk("sb_drained", sb.size(), 0);
    chk("drained_out_valid", out_valid, 0);
    chk("idle_bubble_sat4", s_bubble_cnt, 15);

    // Asynchronous reset while holding two entries
    in_valid = 1'b1; out_ready = 1'b0; flush = 1'b0; in_data = 'h55;
    step();
    step();
    chk("pre_rst_in_ready", in_ready, 0);
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst_out_valid", out_valid, 0);
    chk("async_rst_in_ready", in_ready, 1);
    chk("async_rst_out_data", out_data, 0);
    chk("async_rst_stall_cnt", stall_cnt, 0);
    chk("async_rst_bubble_cnt", bubble_cnt, 0);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    step();
    chk("post_rst_out_valid", out_valid, 0);

    // Narrow counter saturates under a long stall
    s_in_valid = 1'b1; s_in_data = 8'h5A; s_out_ready = 1'b0;
    step();
    s_in_valid = 1'b0;
    for (int i = 0; i < 20; i++) step();
    chk("sat4_stall_cnt", s_stall_cnt, 15);
    chk("sat4_out_data", s_out_data, 'h5A);
    chk("sat4_out_valid", s_out_valid, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
